// File: rtl/clause_config_sequencer_pkg.sv
// clause_config_sequencer_pkg: default widths, derived bus widths and FSM encoding
package clause_config_sequencer_pkg;
  localparam int CI_W = 4;
  localparam int CB_W = 2;
  localparam int IVI_W = 1;
  localparam int BVI_W = 1;
  localparam int VAR_W = 4;
  localparam int CL_W = 2;
  localparam int NI = 2**IVI_W;
  localparam int NB = 2**BVI_W;
  localparam int NC = 2**CL_W;
  localparam int INT_COEF_W = (NI+1)*CI_W;
  localparam int BOOL_COEF_W = NB*CB_W;
  localparam int GAIN_W = CL_W+1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
endpackage

// File: rtl/clause_config_sequencer_clause_buffer.sv
// clause_config_sequencer_clause_buffer: clause coefficient register file with existing-clause mask
module clause_config_sequencer_clause_buffer #(
  parameter int K = 2,
  parameter int IW = 12,
  parameter int BW = 4,
  localparam int N = 2**K
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [K-1:0]  waddr_i,
  input  logic          wexists_i,
  input  logic [IW-1:0] wint_i,
  input  logic [BW-1:0] wbool_i,
  input  logic [K-1:0]  raddr_i,
  output logic [IW-1:0] rint_o,
  output logic [BW-1:0] rbool_o,
  output logic [N-1:0]  mask_o
);
  logic [IW-1:0] int_q [N];
  logic [BW-1:0] bool_q [N];
  logic [N-1:0]  mask_q;
  // host write port; everything clears on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_q  <= '{default: '0};
      bool_q <= '{default: '0};
      mask_q <= '0;
    end else if (we_i) begin
      int_q[waddr_i]  <= wint_i;
      bool_q[waddr_i] <= wbool_i;
      mask_q[waddr_i] <= wexists_i;
    end
  end
  assign rint_o  = int_q[raddr_i];
  assign rbool_o = bool_q[raddr_i];
  assign mask_o  = mask_q;
endmodule

// File: rtl/clause_config_sequencer.sv
// clause_config_sequencer: replays buffered clauses to the solver, runs it and captures the result
module clause_config_sequencer
  import clause_config_sequencer_pkg::*;
#(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT = CI_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT = CB_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = IVI_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = BVI_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE = VAR_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = CL_W,
  parameter int HOLD_CYCLES = 1,
  localparam int LNI = 2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
  localparam int LNB = 2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
  localparam int LK = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int LNC = 2**LK,
  localparam int ICW = (LNI+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
  localparam int BCW = LNB*MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT,
  localparam int AIW = LNI*MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE,
  localparam int GW = LK+1
) (
  input  logic           in_clk,
  input  logic           in_reset_n,
  input  logic           in_wr_valid,
  output logic           out_wr_ready,
  input  logic [LK-1:0]  in_wr_clause_index,
  input  logic           in_wr_exists,
  input  logic [ICW-1:0] in_wr_coef_int,
  input  logic [BCW-1:0] in_wr_coef_bool,
  input  logic           in_start,
  input  logic [AIW-1:0] in_init_integer,
  input  logic [LNB-1:0] in_init_boolean,
  input  logic           in_abort,
  output logic [LNC-1:0] out_existing_clauses,
  output logic [ICW-1:0] out_clause_coefficients_integer,
  output logic [BCW-1:0] out_clause_coefficients_boolean,
  output logic [LK-1:0]  out_clause_index,
  output logic           out_current_state,
  output logic [AIW-1:0] out_integer_current_assignments,
  output logic [LNB-1:0] out_boolean_current_assignments,
  input  logic           in_ready,
  input  logic [GW-1:0]  in_bestgain,
  input  logic [AIW-1:0] in_best_assignment_integer,
  input  logic [LNB-1:0] in_best_assignment_boolean,
  output logic [GW-1:0]  out_result_gain,
  output logic [AIW-1:0] out_result_integer,
  output logic [LNB-1:0] out_result_boolean,
  output logic           out_done,
  output logic           out_busy
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES-1);
  localparam logic [LK-1:0] CNT_LAST = LK'(LNC-1);
  state_e         state_q;
  logic [LK-1:0]  cnt_q;
  logic [HW-1:0]  hold_q;
  logic           first_q, cur_q, done_q, wr_ready_q;
  logic [AIW-1:0] init_int_q, res_int_q;
  logic [LNB-1:0] init_bool_q, res_bool_q;
  logic [GW-1:0]  gain_q;
  logic           we;
  assign we = wr_ready_q & in_wr_valid;
  clause_config_sequencer_clause_buffer #(.K(LK), .IW(ICW), .BW(BCW)) u_buf (
    .clk_i     (in_clk),
    .rst_ni    (in_reset_n),
    .we_i      (we),
    .waddr_i   (in_wr_clause_index),
    .wexists_i (in_wr_exists),
    .wint_i    (in_wr_coef_int),
    .wbool_i   (in_wr_coef_bool),
    .raddr_i   (cnt_q),
    .rint_o    (out_clause_coefficients_integer),
    .rbool_o   (out_clause_coefficients_boolean),
    .mask_o    (out_existing_clauses)
  );
  // sequencer FSM; write-ready is registered so it reads 0 while in reset and rises one cycle later
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      first_q     <= 1'b0;
      cur_q       <= 1'b0;
      done_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      init_int_q  <= '0;
      init_bool_q <= '0;
      gain_q      <= '0;
      res_int_q   <= '0;
      res_bool_q  <= '0;
    end else if (in_abort) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      cur_q      <= 1'b0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wr_ready_q <= !in_start;
          if (in_start) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            hold_q      <= '0;
            init_int_q  <= in_init_integer;
            init_bool_q <= in_init_boolean;
          end
        end
        LOAD: begin
          if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            if (cnt_q == CNT_LAST) begin
              state_q <= RUN;
              cur_q   <= 1'b1;
              first_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RUN: begin
          first_q <= 1'b0;
          if (!first_q && in_ready) begin
            gain_q     <= in_bestgain;
            res_int_q  <= in_best_assignment_integer;
            res_bool_q <= in_best_assignment_boolean;
            done_q     <= 1'b1;
            cur_q      <= 1'b0;
            state_q    <= IDLE;
            wr_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end
  assign out_wr_ready                    = wr_ready_q;
  assign out_clause_index                = cnt_q;
  assign out_current_state               = cur_q;
  assign out_integer_current_assignments = init_int_q;
  assign out_boolean_current_assignments = init_bool_q;
  assign out_result_gain                 = gain_q;
  assign out_result_integer              = res_int_q;
  assign out_result_boolean              = res_bool_q;
  assign out_done                        = done_q;
  assign out_busy                        = state_q != IDLE;
endmodule

// File: tb/tb_clause_config_sequencer.sv
// tb_clause_config_sequencer: directed checks of clause replay, run/capture, abort and reset
module tb_clause_config_sequencer;
  logic clk = 1'b0;
  logic rst_n, wr_valid, wr_exists, start, abort, ready;
  logic [1:0] wr_idx, init_bool, best_bool;
  logic [11:0] wr_int;
  logic [3:0] wr_bool;
  logic [7:0] init_int, best_int;
  logic [2:0] best_gain;
  logic a_wr_ready, a_cur, a_done, a_busy, b_wr_ready, b_cur, b_done, b_busy;
  logic [3:0] a_exist, a_cbool, b_exist, b_cbool;
  logic [11:0] a_cint, b_cint;
  logic [1:0] a_idx, a_abool, a_rbool, b_idx, b_abool, b_rbool;
  logic [7:0] a_aint, a_rint, b_aint, b_rint;
  logic [2:0] a_gain, b_gain;
  logic [11:0] tint [4] = '{12'h411, 12'h511, 12'h611, 12'h311};
  logic [3:0] tbool [4] = '{4'hF, 4'hB, 4'hB, 4'hF};
  logic [63:0] got, exp;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  clause_config_sequencer #(.HOLD_CYCLES(1)) u_dut (
    .in_clk(clk), .in_reset_n(rst_n), .in_wr_valid(wr_valid), .out_wr_ready(a_wr_ready),
    .in_wr_clause_index(wr_idx), .in_wr_exists(wr_exists), .in_wr_coef_int(wr_int),
    .in_wr_coef_bool(wr_bool), .in_start(start), .in_init_integer(init_int),
    .in_init_boolean(init_bool), .in_abort(abort), .out_existing_clauses(a_exist),
    .out_clause_coefficients_integer(a_cint), .out_clause_coefficients_boolean(a_cbool),
    .out_clause_index(a_idx), .out_current_state(a_cur),
    .out_integer_current_assignments(a_aint), .out_boolean_current_assignments(a_abool),
    .in_ready(ready), .in_bestgain(best_gain), .in_best_assignment_integer(best_int),
    .in_best_assignment_boolean(best_bool), .out_result_gain(a_gain),
    .out_result_integer(a_rint), .out_result_boolean(a_rbool), .out_done(a_done),
    .out_busy(a_busy));
  clause_config_sequencer #(.HOLD_CYCLES(3)) u_dut3 (
    .in_clk(clk), .in_reset_n(rst_n), .in_wr_valid(wr_valid), .out_wr_ready(b_wr_ready),
    .in_wr_clause_index(wr_idx), .in_wr_exists(wr_exists), .in_wr_coef_int(wr_int),
    .in_wr_coef_bool(wr_bool), .in_start(start), .in_init_integer(init_int),
    .in_init_boolean(init_bool), .in_abort(abort), .out_existing_clauses(b_exist),
    .out_clause_coefficients_integer(b_cint), .out_clause_coefficients_boolean(b_cbool),
    .out_clause_index(b_idx), .out_current_state(b_cur),
    .out_integer_current_assignments(b_aint), .out_boolean_current_assignments(b_abool),
    .in_ready(ready), .in_bestgain(best_gain), .in_best_assignment_integer(best_int),
    .in_best_assignment_boolean(best_bool), .out_result_gain(b_gain),
    .out_result_integer(b_rint), .out_result_boolean(b_rbool), .out_done(b_done),
    .out_busy(b_busy));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic abort_both();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask
  task automatic test_reset();
    {rst_n, wr_valid, wr_exists, start, abort, ready} = '0;
    {wr_idx, wr_int, wr_bool, init_int, init_bool, best_gain, best_int, best_bool} = '0;
    repeat (2) tick();
    got = {a_wr_ready, a_exist, a_cint, a_cbool, a_idx, a_cur, a_aint, a_abool, a_gain, a_rint, a_rbool, a_done, a_busy};
    exp = '0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_a: got %h expected %h", got, exp); end
    got = {b_wr_ready, b_exist, b_cint, b_cbool, b_idx, b_cur, b_aint, b_abool, b_gain, b_rint, b_rbool, b_done, b_busy};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_b: got %h expected %h", got, exp); end
    rst_n = 1'b1;
    tick();
    got = {a_wr_ready, a_busy, b_wr_ready, b_busy};
    exp = {1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ready_after_reset: got %h expected %h", got, exp); end
  endtask
  task automatic test_write();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_idx = 2'(i); wr_int = tint[i]; wr_bool = tbool[i]; wr_exists = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
  endtask
  task automatic test_load();
    init_int = 8'h11; init_bool = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 13; t++) begin
      if (t < 4) begin
        got = {a_idx, a_cint, a_cbool, a_exist, a_cur, a_busy, a_wr_ready};
        exp = {2'(t), tint[t], tbool[t], 4'hF, 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL load_a t=%0d: got %h expected %h", t, got, exp); end
      end
      if (t == 4) begin
        got = {a_cur, a_busy, a_aint, a_abool, a_idx, a_cint, a_done};
        exp = {1'b1, 1'b1, 8'h11, 2'b10, 2'd3, tint[3], 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_start_a: got %h expected %h", got, exp); end
      end
      if (t < 12) begin
        got = {b_idx, b_cint, b_cbool, b_cur};
        exp = {2'(t/3), tint[t/3], tbool[t/3], 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL load_hold3 t=%0d: got %h expected %h", t, got, exp); end
      end
      if (t == 12) begin
        got = {b_cur, b_aint, b_abool};
        exp = {1'b1, 8'h11, 2'b10};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_start_hold3: got %h expected %h", got, exp); end
      end
      tick();
    end
    abort_both();
  endtask
  task automatic test_ready_early();
    ready = 1'b1; best_gain = 3'b100; best_int = 8'h23; best_bool = 2'b01;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    got = {a_cur, a_done};
    exp = {1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL first_run_cycle: got %h expected %h", got, exp); end
    tick();
    got = {a_cur, a_done, a_busy, a_gain};
    exp = {1'b1, 1'b0, 1'b1, 3'b000};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL stale_ready_ignored: got %h expected %h", got, exp); end
    tick();
    got = {a_done, a_cur, a_busy, a_gain, a_rint, a_rbool};
    exp = {1'b1, 1'b0, 1'b0, 3'b100, 8'h23, 2'b01};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL capture: got %h expected %h", got, exp); end
    tick();
    got = {a_done, a_gain, a_rint, a_rbool};
    exp = {1'b0, 3'b100, 8'h23, 2'b01};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL done_pulse_width: got %h expected %h", got, exp); end
    repeat (6) tick();
    got = {b_done, b_cur};
    exp = {1'b0, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL stale_ready_hold3: got %h expected %h", got, exp); end
    tick();
    got = {b_done, b_cur, b_gain, b_rint, b_rbool};
    exp = {1'b1, 1'b0, 3'b100, 8'h23, 2'b01};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL capture_hold3: got %h expected %h", got, exp); end
    ready = 1'b0; best_gain = 3'b011; best_int = 8'h45; best_bool = 2'b10;
    tick();
  endtask
  task automatic test_busy_ignore();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      if (t < 4) begin
        got = {a_idx, a_cint, a_cbool, a_exist, a_wr_ready, a_busy};
        exp = {2'(t), tint[t], tbool[t], 4'hF, 1'b0, 1'b1};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL busy_replay t=%0d: got %h expected %h", t, got, exp); end
      end
      if (t == 4) begin
        got = {a_cur, a_busy, a_idx, a_gain, a_rint, a_rbool};
        exp = {1'b1, 1'b1, 2'd3, 3'b100, 8'h23, 2'b01};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL busy_no_restart: got %h expected %h", got, exp); end
      end
      if (t == 1) begin
        wr_valid = 1'b1; wr_idx = 2'd2; wr_int = 12'hABC; wr_bool = 4'h0; wr_exists = 1'b0; start = 1'b1;
      end
      if (t == 2) begin
        wr_valid = 1'b0; start = 1'b0;
      end
      tick();
    end
    abort_both();
  endtask
  task automatic test_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    got = {a_cur, a_busy};
    exp = {1'b1, 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL second_run_cycle: got %h expected %h", got, exp); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    got = {a_busy, a_cur, a_done, a_gain, a_rint, a_rbool, b_busy};
    exp = {1'b0, 1'b0, 1'b0, 3'b100, 8'h23, 2'b01, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL abort: got %h expected %h", got, exp); end
    tick();
    got = {a_done, a_busy, a_wr_ready, a_gain};
    exp = {1'b0, 1'b0, 1'b1, 3'b100};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL abort_settled: got %h expected %h", got, exp); end
  endtask
  task automatic test_reset_mid_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    got = {a_wr_ready, a_exist, a_cint, a_cbool, a_idx, a_cur, a_aint, a_abool, a_gain, a_rint, a_rbool, a_done, a_busy};
    exp = '0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset_a: got %h expected %h", got, exp); end
    got = {b_exist, b_cint, b_idx, b_busy, b_gain};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset_b: got %h expected %h", got, exp); end
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = {a_exist, a_busy, a_cint, a_cbool, a_idx};
    exp = {4'h0, 1'b1, 12'h000, 4'h0, 2'd0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mask_after_reset: got %h expected %h", got, exp); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_load();
    test_ready_early();
    test_busy_ignore();
    test_abort();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clause_config_sequencer.md
Name: clause_config_sequencer

Overview:
- Initiator/writer side of the StochasticSearch setup interface.
- Host loads clause coefficients into an internal clause buffer.
- On start, the block replays every clause onto the solver's clause-index/coefficient bus one at a time, then asserts current_state with the initial assignments.
- It waits for the solver's ready, captures best gain and best assignment, and reports done. It replaces hand-written testbench stimulus with synthesizable sequencing.

Parameters:
- MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT, 4, integer coefficient width (CI).
- MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT, 2, boolean coefficient width (CB).
- MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX, 1, log2 integer variable count (NI=2**this).
- MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX, 1, log2 boolean variable count (NB=2**this).
- MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE, 4, integer variable value width (VW).
- MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX, 2, log2 clause count (NC=2**this, index width K).
- HOLD_CYCLES, 1, cycles each clause is held on the config bus (≥1).

Ports:
- in_clk  in  1  clock, rising edge.
- in_reset_n  in  1  asynchronous active-low reset.
- in_wr_valid  in  1  host clause write request.
- out_wr_ready  out  1  write accepted this cycle (high only in IDLE).
- in_wr_clause_index  in  K  clause slot written.
- in_wr_exists  in  1  sets/clears slot's bit in existing mask.
- in_wr_coef_int  in  (NI+1)*CI  integer coefficients plus bias.
- in_wr_coef_bool  in  NB*CB  boolean coefficients.
- in_start  in  1  start pulse.
- in_init_integer  in  NI*VW  initial integer assignment, sampled at start.
- in_init_boolean  in  NB  initial boolean assignment, sampled at start.
- in_abort  in  1  return to IDLE from any state.
- out_existing_clauses  out  NC  to solver.
- out_clause_coefficients_integer  out  (NI+1)*CI  to solver.
- out_clause_coefficients_boolean  out  NB*CB  to solver.
- out_clause_index  out  K  to solver.
- out_current_state  out  1  solver enable.
- out_integer_current_assignments  out  NI*VW  to solver.
- out_boolean_current_assignments  out  NB  to solver.
- in_ready  in  1  solver out_ready.
- in_bestgain  in  K+1  solver best gain.
- in_best_assignment_integer  in  NI*VW  solver result.
- in_best_assignment_boolean  in  NB  solver result.
- out_result_gain  out  K+1  captured gain.
- out_result_integer  out  NI*VW  captured integer assignment.
- out_result_boolean  out  NB  captured boolean assignment.
- out_done  out  1  one-cycle pulse on capture.
- out_busy  out  1  high in LOAD/RUN.

Behaviour:

Reset:
- All outputs are 0.
- Clause buffer and existing mask are cleared.
- FSM enters IDLE.

States: IDLE, LOAD, RUN.

IDLE:
- out_wr_ready=1. A write with in_wr_valid stores the coefficients and the exists bit at in_wr_clause_index on the clock edge.
- in_start latches the init assignments and moves to LOAD with clause counter=0 and hold counter=0.
- Write and start in the same cycle: both are accepted, and the written clause is replayed.

LOAD:
- Config bus drives buffer[counter]; out_clause_index=counter; out_existing_clauses=mask.
- Each clause is held HOLD_CYCLES cycles, and the counter advances 0..NC-1 in order. Non-existing slots are still replayed.
- After the last clause's hold, the FSM goes to RUN.
- LOAD duration is exactly NC*HOLD_CYCLES cycles.

RUN:
- out_current_state=1 and the assignment outputs drive the latched init values. The config bus keeps its last clause.
- in_ready is ignored in the first RUN cycle, to discard stale ready from a prior run.
- On in_ready=1 in any later cycle:
  - capture in_bestgain and both best assignments into the result registers;
  - pulse out_done for 1 cycle;
  - drop out_current_state next cycle;
  - return to IDLE.

Other rules:
- out_busy = (state != IDLE).
- in_start while busy is ignored. in_wr_valid while busy is refused (out_wr_ready=0, buffer unchanged).
- in_abort has priority over everything except reset. Next state is IDLE, out_current_state=0, no out_done, and results are unchanged. The buffer is preserved.
- Result registers hold until the next capture.
- Reset mid-LOAD or mid-RUN: immediate clear, per the reset rule.
- Widths are fixed by the parameters; there is no arithmetic beyond the counters. The clause counter wraps naturally at NC but is never used past NC-1.

Decomposition:
- Shared package holds:
  - the derived widths: NI, NB, NC, coefficient bus widths, gain width K+1;
  - the FSM state encoding IDLE/LOAD/RUN.
- One sub-module, clause_buffer: NC-entry register file with one write port (host) and one read port (counter index), plus the existing mask register.

Test Plan:
1. Reset, then write clauses 0..3 = int 12'h411, 12'h511, 12'h611, 12'h311 and bool 4'hF, 4'hB, 4'hB, 4'hF, all exists, then start with init int 8'h11, bool 2'b10 → out_existing_clauses=4'hF; bus shows index 0..3 with matching coefficients, 1 cycle each; out_current_state rises exactly 4 cycles after the start cycle.
2. HOLD_CYCLES=3, same load → each index is held 3 cycles; RUN begins 12 cycles after start.
3. in_ready held high from before start → ignored in the first RUN cycle; capture on the second RUN cycle. A model returning gain 3'b100, int 8'h23, bool 2'b01 yields out_done pulse and results 3'b100/8'h23/2'b01.
4. in_wr_valid and in_start during LOAD → out_wr_ready=0, buffer unchanged, no restart; the replayed sequence matches the original.
5. in_abort at the 2nd RUN cycle with in_ready=0 → IDLE next cycle, out_current_state=0, no out_done, previous results retained.
6. in_reset_n low during LOAD → all outputs 0 asynchronously; existing mask reads 4'h0 on the next start.
